// File: rtl/hazard_control.sv
// hazard_control: execute-stage hazard sequencer.
// Tracks the destinations of the instructions in EX, MM and WB, produces
// bypass selects for decode's rs1/rs2, raises load-use stalls and flushes the
// front end after a taken branch/jump resolved in execute.
// Build option HAZARD_FORWARD_EN: when defined, results are bypassed and only
// a load sitting in EX stalls; when undefined, no bypassing happens and any
// in-flight producer of a used source stalls decode until it leaves WB.
module hazard_control #(
  parameter int REG_W        = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             adv,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_wr,
  input  logic             id_load,
  input  logic             ex_branch,
  output logic             stall,
  output logic             flush,
  output logic [1:0]       fwd_rs1,
  output logic [1:0]       fwd_rs2
);

  // Remaining-flush counter; FLUSH_CYCLES is limited to 1..4.
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             load;
  } sb_entry_t;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  sb_entry_t        ex_q, ex_d;
  sb_entry_t        mm_q, mm_d;
  sb_entry_t        wb_q, wb_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic branch_take;
  logic hazard;
  logic rs1_hit_ex, rs1_hit_mm, rs1_hit_wb;
  logic rs2_hit_ex, rs2_hit_mm, rs2_hit_wb;

  // The load flag of the oldest entry has no consumer: a load leaving WB can
  // no longer cause a hazard.
  logic unused_wb_load;
  assign unused_wb_load = wb_q.load;

  // A scoreboard entry matches only when valid; x0 entries are never valid.
  function automatic logic match(input sb_entry_t e, input logic [REG_W-1:0] r);
    return e.v && (e.rd == r);
  endfunction

  // Per-source hit flags, already qualified by the source's use flag.
  always_comb begin
    rs1_hit_ex = id_use_rs1 & match(ex_q, id_rs1);
    rs1_hit_mm = id_use_rs1 & match(mm_q, id_rs1);
    rs1_hit_wb = id_use_rs1 & match(wb_q, id_rs1);
    rs2_hit_ex = id_use_rs2 & match(ex_q, id_rs2);
    rs2_hit_mm = id_use_rs2 & match(mm_q, id_rs2);
    rs2_hit_wb = id_use_rs2 & match(wb_q, id_rs2);
  end

  // Bypass selects and raw hazard detection for the selected build option.
  always_comb begin
    fwd_rs1 = 2'd0;
    fwd_rs2 = 2'd0;
    hazard  = 1'b0;
`ifdef HAZARD_FORWARD_EN
    // Youngest producer wins: EX, then MM, then WB.
    if (rs1_hit_ex)      fwd_rs1 = 2'd1;
    else if (rs1_hit_mm) fwd_rs1 = 2'd2;
    else if (rs1_hit_wb) fwd_rs1 = 2'd3;
    if (rs2_hit_ex)      fwd_rs2 = 2'd1;
    else if (rs2_hit_mm) fwd_rs2 = 2'd2;
    else if (rs2_hit_wb) fwd_rs2 = 2'd3;
    // Only a load in EX cannot be bypassed in time.
    hazard = id_valid & ex_q.load & (rs1_hit_ex | rs2_hit_ex);
`else
    // Without bypassing, wait for every in-flight producer to retire.
    hazard = id_valid & (rs1_hit_ex | rs1_hit_mm | rs1_hit_wb |
                         rs2_hit_ex | rs2_hit_mm | rs2_hit_wb);
`endif
  end

  // Flush starts in the cycle the taken branch advances out of execute and
  // continues while in FLUSH; a flush always suppresses the stall.
  always_comb begin
    branch_take = ex_branch & adv & (state_q == ST_RUN);
    flush       = (state_q == ST_FLUSH) | branch_take;
    stall       = hazard & ~flush;
  end

  // Flush FSM next state: count holds the flush cycles still owed in FLUSH.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_RUN: begin
        if (branch_take && (FLUSH_CYCLES > 1)) begin
          state_d = ST_FLUSH;
          count_d = FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (adv) begin
          if (count_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
            count_d = '0;
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        count_d = '0;
      end
    endcase
  end

  // Scoreboard shift: entries move one stage per advance; stalled, flushed,
  // non-writing and x0-writing instructions enter EX as bubbles.
  always_comb begin
    ex_d = ex_q;
    mm_d = mm_q;
    wb_d = wb_q;
    if (adv) begin
      wb_d      = mm_q;
      mm_d      = ex_q;
      ex_d.v    = id_valid & id_wr & ~stall & ~flush & (id_rd != '0);
      ex_d.rd   = id_rd;
      ex_d.load = id_load & ex_d.v;
    end
  end

  // State registers with asynchronous reset to an empty, running pipeline.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ex_q    <= '0;
      mm_q    <= '0;
      wb_q    <= '0;
      state_q <= ST_RUN;
      count_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mm_q    <= mm_d;
      wb_q    <= wb_d;
      state_q <= state_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// Directed self-checking bench for hazard_control. Expectations follow the
// build option HAZARD_FORWARD_EN. A second instance with FLUSH_CYCLES = 1
// shares the inputs to check the single-pulse flush.
module tb_hazard_control;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       aclk = 1'b0;
  logic       areset;
  logic       adv;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_wr, id_load;
  logic       ex_branch;
  logic       stall, flush;
  logic [1:0] fwd_rs1, fwd_rs2;
  logic       stall1, flush1;
  logic [1:0] fwd1_rs1, fwd1_rs2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 aclk = ~aclk;

  hazard_control #(.REG_W(5), .FLUSH_CYCLES(2)) u_dut (
    .aclk(aclk), .areset(areset), .adv(adv), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wr(id_wr),
    .id_load(id_load), .ex_branch(ex_branch), .stall(stall),
    .flush(flush), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2)
  );

  hazard_control #(.REG_W(5), .FLUSH_CYCLES(1)) u_dut1 (
    .aclk(aclk), .areset(areset), .adv(adv), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wr(id_wr),
    .id_load(id_load), .ex_branch(ex_branch), .stall(stall1),
    .flush(flush1), .fwd_rs1(fwd1_rs1), .fwd_rs2(fwd1_rs2)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic ld, input logic br, input logic a);
    id_valid   = v;
    id_rs1     = rs1;
    id_rs2     = rs2;
    id_use_rs1 = u1;
    id_use_rs2 = u2;
    id_rd      = rd;
    id_wr      = wr;
    id_load    = ld;
    ex_branch  = br;
    adv        = a;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
    end
  endtask

  initial begin
    areset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    chk("rst_stall", stall, 0);
    chk("rst_flush", flush, 0);
    chk("rst_fwd1", fwd_rs1, 0);
    chk("rst_fwd2", fwd_rs2, 0);
    chk("rst_d1_stall", stall1, 0);
    chk("rst_d1_fwd", {fwd1_rs1, fwd1_rs2}, 0);
    tick();
    tick();
    areset = 1'b0;

    // Reader of x3 against an empty scoreboard.
    drive(1, 3, 0, 1, 0, 0, 0, 0, 0, 1);
    #1;
    chk("empty_stall", stall, 0);
    chk("empty_flush", flush, 0);
    chk("empty_fwd1", fwd_rs1, 0);
    tick();

    // ADD x5, then a reader of x5 held in decode for four advances.
    drive(1, 1, 2, 1, 1, 5, 1, 0, 0, 1);
    #1;
    chk("add5_stall", stall, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 5, 0, 1, 0, 0, 0, 0, 0, 1);
      #1;
      chk($sformatf("dep5_fwd1_k%0d", k), fwd_rs1, FWD ? ((k < 3) ? k + 1 : 0) : 0);
      chk($sformatf("dep5_stall_k%0d", k), stall, FWD ? 0 : ((k < 3) ? 1 : 0));
      $display("step dep5 k=%0d stall=%0d fwd_rs1=%0d", k, stall, fwd_rs1);
      tick();
    end

    // LW x7, then ADD x8 reading rs1=x8 and rs2=x7.
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 1);
    #1;
    chk("lw7_stall", stall, 0);
    tick();
`ifdef HAZARD_FORWARD_EN
    drive(1, 8, 7, 1, 1, 8, 1, 0, 0, 1);
    #1;
    chk("lu_stall_0", stall, 1);
    chk("lu_fwd2_0", fwd_rs2, 1);
    tick();
    drive(1, 8, 7, 1, 1, 8, 1, 0, 0, 1);
    #1;
    chk("lu_stall_1", stall, 0);
    chk("lu_fwd2_1", fwd_rs2, 2);
    chk("lu_bubble_fwd1", fwd_rs1, 0);
    tick();
`else
    for (int k = 0; k < 4; k++) begin
      drive(1, 8, 7, 1, 1, 8, 1, 0, 0, 1);
      #1;
      chk($sformatf("lu_stall_k%0d", k), stall, (k < 3) ? 1 : 0);
      chk($sformatf("lu_fwd_k%0d", k), {fwd_rs1, fwd_rs2}, 0);
      tick();
    end
`endif
    $display("step load-use done");
    idle(3);

    // LW x9, then branch held off by adv=0, then taken with a load-use pending.
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 1);
    #1;
    chk("lw9_stall", stall, 0);
    tick();
    drive(1, 9, 10, 1, 1, 10, 1, 0, 1, 0);
    #1;
    chk("br_noadv_flush", flush, 0);
    chk("br_noadv_d1_flush", flush1, 0);
    chk("br_noadv_stall", stall, 1);
    tick();
    drive(1, 9, 10, 1, 1, 10, 1, 0, 1, 1);
    #1;
    chk("br0_flush", flush, 1);
    chk("br0_stall", stall, 0);
    chk("br0_d1_flush", flush1, 1);
    chk("br0_d1_stall", stall1, 0);
    chk("br0_fwd1", fwd_rs1, FWD ? 1 : 0);
    tick();
    drive(1, 9, 10, 1, 1, 10, 1, 0, 0, 1);
    #1;
    chk("br1_flush", flush, 1);
    chk("br1_stall", stall, 0);
    chk("br1_fwd1", fwd_rs1, FWD ? 2 : 0);
    chk("br1_fwd2", fwd_rs2, 0);
    chk("br1_d1_flush", flush1, 0);
    chk("br1_d1_stall", stall1, FWD ? 0 : 1);
    tick();
    drive(1, 9, 10, 1, 1, 10, 1, 0, 0, 1);
    #1;
    chk("br2_flush", flush, 0);
    chk("br2_fwd1", fwd_rs1, FWD ? 3 : 0);
    chk("br2_fwd2_nowrite", fwd_rs2, 0);
    chk("br2_stall", stall, FWD ? 0 : 1);
    $display("step branch flush done");
    tick();
    idle(3);

    // Write to x0, then readers of x0.
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
    #1;
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1, 0, 0, 1, 1, 0, 0, 0, 0, 1);
      #1;
      chk($sformatf("x0_fwd_k%0d", k), {fwd_rs1, fwd_rs2}, 0);
      chk($sformatf("x0_stall_k%0d", k), stall, 0);
      tick();
    end

    // Writer of x11, then reader held with adv=0 for three cycles.
    drive(1, 0, 0, 0, 0, 11, 1, 0, 0, 1);
    #1;
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 11, 0, 1, 0, 0, 0, 0, 0, (k == 3) ? 1'b1 : 1'b0);
      #1;
      chk($sformatf("hold_fwd1_k%0d", k), fwd_rs1, FWD ? 1 : 0);
      chk($sformatf("hold_stall_k%0d", k), stall, FWD ? 0 : 1);
      tick();
    end
    drive(1, 11, 0, 1, 0, 0, 0, 0, 0, 1);
    #1;
    chk("hold_after_fwd1", fwd_rs1, FWD ? 2 : 0);
    chk("hold_after_stall", stall, FWD ? 0 : 1);
    $display("step adv hold done");
    tick();
    idle(3);

    // Reset pulsed while in FLUSH with one flush cycle still owed.
    drive(1, 0, 0, 0, 0, 12, 1, 0, 0, 1);
    #1;
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    #1;
    chk("rf_br_flush", flush, 1);
    chk("rf_br_d1_flush", flush1, 1);
    tick();
    drive(1, 12, 0, 1, 0, 0, 0, 0, 0, 1);
    #1;
    chk("rf_pre_flush", flush, 1);
    chk("rf_pre_fwd1", fwd_rs1, FWD ? 2 : 0);
    areset = 1'b1;
    #1;
    chk("rf_in_flush", flush, 0);
    chk("rf_in_fwd1", fwd_rs1, 0);
    chk("rf_in_stall", stall, 0);
    #1;
    areset = 1'b0;
    #1;
    chk("rf_out_flush", flush, 0);
    tick();
    drive(1, 12, 0, 1, 0, 0, 0, 0, 0, 1);
    #1;
    chk("rf_next_flush", flush, 0);
    chk("rf_next_stall", stall, 0);
    chk("rf_next_fwd1", fwd_rs1, 0);
    $display("step reset-in-flush done");
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
